sample_arbiter: RTL and testbench



---
 rtl/sample_arbiter_pkg.sv | 52 +++++
 rtl/sample_arbiter_if.sv | 28 ++
 rtl/sample_arbiter_slot.sv | 54 +++++
 rtl/sample_arbiter.sv | 135 +++++++++++++
 tb/tb_sample_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_arbiter_pkg
// Description : Shared types, constants and the channel-search helper for the
//               sample arbiter.
//               - arb_state_t : scheduler state encoding (IDLE / BUSY)
//               - DROP_CNT_W  : width of the per-channel drop counters
//               - rr_select() : rotating search for the next pending channel
// Optional    : SAMPLE_ARBITER_DROP_CNT_EN (consumed by sample_arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
package sample_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DROP_CNT_W = 8;

  // The search helper works on the widest legal configuration; callers
  // zero-extend their pend vector and pointer.
  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = 4;

  // Returns {found, idx}: the first set bit of pend at or after ptr, wrapping
  // modulo n. Fixed priority is obtained by calling it with ptr = 0.
  function automatic logic [MAX_IDX_W:0] rr_select(
    input logic [MAX_N-1:0]     pend,
    input logic [MAX_IDX_W-1:0] ptr,
    input int                   n
  );
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
    int                   c;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        c = int'(ptr) + k;
        if (c >= n) c = c - n;
        if (!found && pend[c[MAX_IDX_W-1:0]]) begin
          found = 1'b1;
          idx   = c[MAX_IDX_W-1:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dti
// Description : Valid/ready data-transfer interface. A word moves on every
//               cycle where valid and ready are both high.
// Ports       : valid - producer has a word on data
//               ready - consumer accepts the word this cycle
//               data  - payload, W bits
// Modports    : producer / master - drives valid, data; samples ready
//               consumer / slave  - samples valid, data; drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface dti #(
  parameter int W = 8
) ();
  import sample_arbiter_pkg::*;

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
  modport master   (output valid, output data, input  ready);
  modport slave    (input  valid, input  data, output ready);

endinterface
`default_nettype wire

// File: rtl/sample_arbiter_slot.sv
`default_nettype none
// ============================================================================
// Module      : sample_slot
// Description : Single-entry, overwrite-on-write sample holder for one
//               arbiter channel.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               wr_en     - new sample present this cycle
//               wr_data   - new sample value
//               clr       - slot is being captured by the scheduler
//               data      - held sample
//               pend      - held sample not yet forwarded
//               drop      - an unforwarded sample is overwritten this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sample_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         clr,
  output logic [W-1:0] data,
  output logic         pend,
  output logic         drop
);
  import sample_arbiter_pkg::*;

  logic [W-1:0] r_data;
  logic         r_pend;

  // A write in the same cycle as a capture wins: the scheduler takes the old
  // value while the new one stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_pend <= 1'b0;
    end else begin
      if (wr_en) begin
        r_data <= wr_data;
        r_pend <= 1'b1;
      end else if (clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign data = r_data;
  assign pend = r_pend;
  // Overwriting a sample that is simultaneously captured loses nothing.
  assign drop = wr_en && r_pend && !clr;

endmodule
`default_nettype wire

// File: rtl/sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sample_arbiter
// Description : Shares one downstream dti consumer among N sampled sources.
//               Each source owns an always-ready, overwrite-on-new-data slot;
//               a round-robin (PRIO=0) or fixed-priority (PRIO=1) scheduler
//               forwards pending samples as {idx, data} words.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               din[N]    - input sample streams (dti.consumer, W bits)
//               dout      - output stream (dti.producer, IDX_W+W bits,
//                           channel index in the MSBs)
//               drop_cnt  - per-channel saturating lost-sample counters
//                           (present only with SAMPLE_ARBITER_DROP_CNT_EN)
// Parameters  : N (2..16), PRIO (0 rr / 1 fixed), W (must equal din width)
// Optional    : SAMPLE_ARBITER_DROP_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module sample_arbiter
  import sample_arbiter_pkg::*;
#(
  parameter int N    = 2,
  parameter int PRIO = 0,
  parameter int W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  dti.consumer        din [N],
  dti.producer        dout
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt [N]
`endif
);

  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

  // --------------------------------------------------------------------------
  // Per-channel sample slots
  // --------------------------------------------------------------------------
  logic [W-1:0] w_slot_data [N];
  logic [N-1:0] w_pend;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_drop;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign din[i].ready = 1'b1;

    sample_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (din[i].valid),
      .wr_data (din[i].data),
      .clr     (w_clr[i]),
      .data    (w_slot_data[i]),
      .pend    (w_pend[i]),
      .drop    (w_drop[i])
    );
  end

  // --------------------------------------------------------------------------
  // Scheduler: selection works only from registered slot state, so a write
  // landing in a capture cycle is seen one cycle later.
  // --------------------------------------------------------------------------
  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W+W-1:0] r_out;

  logic [MAX_IDX_W-1:0] w_ptr_sel;
  logic [MAX_IDX_W:0]   w_rr;
  logic                 w_found;
  logic [IDX_W-1:0]     w_sel;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic                 w_cap;

  assign w_ptr_sel = (PRIO != 0) ? '0 : MAX_IDX_W'(r_ptr);
  assign w_rr      = rr_select(MAX_N'(w_pend), w_ptr_sel, N);
  // The range guard also keeps every bit of the helper's result meaningful.
  assign w_found   = w_rr[MAX_IDX_W] &&
                     ({1'b0, w_rr[MAX_IDX_W-1:0]} < (MAX_IDX_W+1)'(N));
  assign w_sel     = w_rr[IDX_W-1:0];
  assign w_ptr_nxt = (w_sel == IDX_W'(N-1)) ? '0 : w_sel + 1'b1;

  // Capture when the output register is free: empty, or emptying this cycle.
  assign w_cap = w_found && ((r_state == IDLE) || dout.ready);

  always_comb begin
    w_clr = '0;
    if (w_cap) w_clr[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_out   <= '0;
    end else begin
      if (w_cap) begin
        r_out <= {w_sel, w_slot_data[w_sel]};
        r_ptr <= w_ptr_nxt;
      end
      case (r_state)
        IDLE:    if (w_cap) r_state <= BUSY;
        BUSY:    if (dout.ready && !w_cap) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout.valid = (r_state == BUSY);
  assign dout.data  = r_out;

  // --------------------------------------------------------------------------
  // Lost-sample accounting
  // --------------------------------------------------------------------------
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
  for (genvar i = 0; i < N; i++) begin : g_drop
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_drop_cnt <= '0;
      end else if (w_drop[i] && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end

    assign drop_cnt[i] = r_drop_cnt;
  end
`else
  logic w_unused_drop;
  assign w_unused_drop = ^w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_arbiter
// Description : Self-checking bench for sample_arbiter. Three instances:
//               A (N=2, round-robin) driven from a cycle table and short
//               hand-written sequences; B (N=4, round-robin) and C (N=4,
//               fixed priority) fed all-valid traffic and checked against
//               scoreboard queues.
// Optional    : SAMPLE_ARBITER_DROP_CNT_EN (drop counters also checked)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_arbiter;
  import sample_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  dti #(.W(8))  a_din [2] ();
  dti #(.W(9))  a_dout ();
  dti #(.W(8))  b_din [4] ();
  dti #(.W(10)) b_dout ();
  dti #(.W(8))  c_din [4] ();
  dti #(.W(10)) c_dout ();

  logic       a_v [2];
  logic [7:0] a_d [2];
  logic       a_rdy;
  logic       bc_v;
  logic [7:0] bc_d [4];

  for (genvar g = 0; g < 2; g++) begin : g_a
    assign a_din[g].valid = a_v[g];
    assign a_din[g].data  = a_d[g];
  end
  for (genvar g = 0; g < 4; g++) begin : g_bc
    assign b_din[g].valid = bc_v;
    assign b_din[g].data  = bc_d[g];
    assign c_din[g].valid = bc_v;
    assign c_din[g].data  = bc_d[g];
  end
  assign a_dout.ready = a_rdy;
  assign b_dout.ready = 1'b1;
  assign c_dout.ready = 1'b1;

`ifdef SAMPLE_ARBITER_DROP_CNT_EN
  logic [7:0] a_drop [2];
  logic [7:0] b_drop [4];
  logic [7:0] c_drop [4];
`endif

  sample_arbiter #(.N(2), .PRIO(0), .W(8)) u_dut_a (
    .clk(clk), .rst(rst), .din(a_din), .dout(a_dout)
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
    , .drop_cnt(a_drop)
`endif
  );
  sample_arbiter #(.N(4), .PRIO(0), .W(8)) u_dut_b (
    .clk(clk), .rst(rst), .din(b_din), .dout(b_dout)
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
    , .drop_cnt(b_drop)
`endif
  );
  sample_arbiter #(.N(4), .PRIO(1), .W(8)) u_dut_c (
    .clk(clk), .rst(rst), .din(c_din), .dout(c_dout)
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
    , .drop_cnt(c_drop)
`endif
  );

  // ---------------------------------------------------------------------------
  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       rdy;
    logic       ev;
    logic [8:0] ew;
  } vec_t;

  vec_t       tbl [$];
  logic [9:0] qb  [$];
  logic [9:0] qc  [$];

  task automatic add(input logic v0, input logic [7:0] d0, input logic v1,
                     input logic [7:0] d1, input logic rdy, input logic ev,
                     input logic [8:0] ew);
    vec_t e;
    e.v0 = v0; e.d0 = d0; e.v1 = v1; e.d1 = d1;
    e.rdy = rdy; e.ev = ev; e.ew = ew;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input logic rdy);
    a_v[0] = v0; a_d[0] = d0; a_v[1] = v1; a_d[1] = d1; a_rdy = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    logic [9:0] exp;

    // Per-cycle table for instance A: inputs held for one cycle, expected
    // outputs observed during that same cycle (so they reflect earlier rows).
    add(1, 8'h11, 1, 8'h22, 1, 0, 9'h000); // 0  both channels at once
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 1
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h011); // 2  ch0 first (ptr=0)
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h122); // 3  ch1 back-to-back
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 4  idle
    add(1, 8'hA1, 0, 8'h00, 0, 0, 9'h000); // 5  overwrite burst, stalled
    add(1, 8'hA2, 0, 8'h00, 0, 0, 9'h000); // 6  A1 captured here
    add(1, 8'hA3, 0, 8'h00, 0, 1, 9'h0A1); // 7  A2 lost
    for (int i = 0; i < 9; i++)
      add(0, 8'h00, 0, 8'h00, 0, 1, 9'h0A1); // 8..16 held under backpressure
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h0A1); // 17 handshake
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h0A3); // 18 freshest sample
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 19
    add(0, 8'h00, 1, 8'h55, 1, 0, 9'h000); // 20 collision setup
    add(0, 8'h00, 1, 8'h66, 1, 0, 9'h000); // 21 write during capture of 0x55
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h155); // 22
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h166); // 23
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 24
    add(1, 8'h5A, 0, 8'h00, 1, 0, 9'h000); // 25 advance ptr to 1
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 26
    add(1, 8'h33, 1, 8'h44, 1, 1, 9'h05A); // 27
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 28
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h144); // 29 rotation: ch1 before ch0
    add(0, 8'h00, 0, 8'h00, 1, 1, 9'h033); // 30
    add(0, 8'h00, 0, 8'h00, 1, 0, 9'h000); // 31

    drive_a(0, 8'h00, 0, 8'h00, 1);
    bc_v = 1'b0;
    for (int i = 0; i < 4; i++) bc_d[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_a_valid", 32'(a_dout.valid), 32'd0);
    chk("reset_a_data",  32'(a_dout.data),  32'd0);
    chk("reset_b_valid", 32'(b_dout.valid), 32'd0);
    chk("reset_c_valid", 32'(c_dout.valid), 32'd0);
    chk("din_ready_a0",  32'(a_din[0].ready), 32'd1);
    chk("din_ready_b3",  32'(b_din[3].ready), 32'd1);
    next_cycle();

    // Table-driven phase
    for (int i = 0; i < tbl.size(); i++) begin
      drive_a(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(a_dout.valid), 32'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_data", i), 32'(a_dout.data), 32'(tbl[i].ew));
      next_cycle();
    end
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
    chk("drop_cnt_a0", 32'(a_drop[0]), 32'd1);
    chk("drop_cnt_a1", 32'(a_drop[1]), 32'd0);
`endif

    // Reset while BUSY with another sample pending
    drive_a(1, 8'h77, 0, 8'h00, 0);
    next_cycle();
    drive_a(0, 8'h00, 1, 8'h99, 0);
    next_cycle();
    drive_a(0, 8'h00, 0, 8'h00, 0);
    @(negedge clk);
    chk("rstp_busy_valid", 32'(a_dout.valid), 32'd1);
    chk("rstp_busy_data",  32'(a_dout.data),  32'h077);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    a_rdy = 1'b1;
    @(negedge clk);
    chk("rstp_after_data", 32'(a_dout.data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstp_quiet%0d", i), 32'(a_dout.valid), 32'd0);
      next_cycle();
    end
`ifdef SAMPLE_ARBITER_DROP_CNT_EN
    chk("rstp_drop_clr", 32'(a_drop[0]), 32'd0);
`endif
    // ptr must be back at 0: ch0 wins despite ch0 being the last one served
    drive_a(1, 8'h01, 1, 8'h02, 1);
    next_cycle();
    drive_a(0, 8'h00, 0, 8'h00, 1);
    @(negedge clk);
    chk("rstp_new_idle", 32'(a_dout.valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rstp_new_valid", 32'(a_dout.valid), 32'd1);
    chk("rstp_new_w0",    32'(a_dout.data),  32'h001);
    next_cycle();
    @(negedge clk);
    chk("rstp_new_w1",    32'(a_dout.data),  32'h102);
    next_cycle();

    // Fairness: all four channels valid every cycle, words tagged by cycle.
    for (int k = 0; k < 24; k++) begin
      if (k < 20) begin
        bc_v = 1'b1;
        for (int i = 0; i < 4; i++) bc_d[i] = {i[1:0], k[5:0]};
        qb.push_back({2'(k % 4), 2'(k % 4), k[5:0]});
        qc.push_back({2'b00, 2'b00, k[5:0]});
      end else begin
        bc_v = 1'b0;
      end
      @(negedge clk);
      if (b_dout.valid && qb.size() > 0) begin
        exp = qb.pop_front();
        chk($sformatf("rr_word%0d", k), 32'(b_dout.data), 32'(exp));
      end else if (k >= 2 && qb.size() > 0) begin
        chk($sformatf("rr_gap%0d", k), 32'(b_dout.valid), 32'd1);
      end
      if (c_dout.valid && qc.size() > 0) begin
        exp = qc.pop_front();
        chk($sformatf("prio_word%0d", k), 32'(c_dout.data), 32'(exp));
      end else if (k >= 2 && qc.size() > 0) begin
        chk($sformatf("prio_gap%0d", k), 32'(c_dout.valid), 32'd1);
      end
      next_cycle();
    end
    chk("rr_left",   32'(qb.size()), 32'd0);
    chk("prio_left", 32'(qc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
